// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared types and width constants for the I2C request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int ADDR_W          = 7;
    localparam int DATA_W          = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        RESP      = 3'd3,
        DRAIN     = 3'd4
    } state_type;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first set
//               request bit at or after ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any
);

    // Scan N positions starting at ptr; the first hit wins
    always_comb begin
        int               kk;
        logic [IDX_W-1:0] idx;
        winner_oh  = '0;
        winner_idx = '0;
        any        = 1'b0;
        kk         = 0;
        idx        = '0;
        for (int i = 0; i < N; i++) begin
            kk = int'(ptr) + i;
            if (kk >= N) begin
                kk = kk - N;
            end
            idx = IDX_W'(kk);
            if (!any && req[idx]) begin
                any            = 1'b1;
                winner_idx     = idx;
                winner_oh[idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_req_arbiter
// Description : Shares one I2C master between NUM_REQ requesters with
//               round-robin arbitration and a transfer watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int TIMEOUT_CYC = 400000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_din,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      m_newd,
    output logic [ADDR_W-1:0]         m_addr,
    output logic                      m_op,
    output logic [DATA_W-1:0]         m_din,
    input  logic                      m_busy,
    input  logic                      m_done,
    input  logic                      m_ack_err,
    input  logic [DATA_W-1:0]         m_dout
);

    localparam int          IDX_W    = $clog2(NUM_REQ);
    localparam logic [31:0] WDOG_MAX = 32'(TIMEOUT_CYC - 1);

    state_type          state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               m_newd_q, m_newd_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic               m_op_q, m_op_d;
    logic [DATA_W-1:0]  m_din_q, m_din_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [31:0]        wdog_q, wdog_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        m_newd_d      = 1'b0;
        m_addr_d      = m_addr_q;
        m_op_d        = m_op_q;
        m_din_d       = m_din_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        wdog_d        = wdog_q;
        case (state_q)
            IDLE: begin
                // Never start while the master still owns the bus
                if (!m_busy && pick_any) begin
                    gnt_d    = pick_oh;
                    win_d    = pick_idx;
                    m_addr_d = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    m_op_d   = req_op[pick_idx];
                    m_din_d  = req_din[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                m_newd_d = 1'b1;
                wdog_d   = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Done takes priority over a watchdog expiring in the same cycle
                if (m_done) begin
                    rsp_data_d    = m_dout;
                    rsp_err_d     = m_ack_err;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = gnt_q;
                    state_d       = RESP;
                end else if (wdog_q >= WDOG_MAX) begin
                    rsp_data_d    = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = gnt_q;
                    state_d       = RESP;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            RESP: begin
                gnt_d   = '0;
                ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                state_d = DRAIN;
            end
            DRAIN: begin
                // After a timeout the master may hold the bus for a long time
                if (!m_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            m_newd_q      <= 1'b0;
            m_addr_q      <= '0;
            m_op_q        <= 1'b0;
            m_din_q       <= '0;
            ptr_q         <= '0;
            win_q         <= '0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            m_newd_q      <= m_newd_d;
            m_addr_q      <= m_addr_d;
            m_op_q        <= m_op_d;
            m_din_q       <= m_din_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            wdog_q        <= wdog_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign m_newd      = m_newd_q;
    assign m_addr      = m_addr_q;
    assign m_op        = m_op_q;
    assign m_din       = m_din_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_req_arbiter
// Description : Self-checking bench for i2c_req_arbiter with a behavioural
//               I2C master model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    localparam int N   = 4;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [3:0]  req_op;
    logic [31:0] req_din;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        m_newd;
    logic [6:0]  m_addr;
    logic        m_op;
    logic [7:0]  m_din;
    logic        m_busy;
    logic        m_done;
    logic        m_ack_err;
    logic [7:0]  m_dout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    i2c_req_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .req_op      (req_op),
        .req_din     (req_din),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .m_newd      (m_newd),
        .m_addr      (m_addr),
        .m_op        (m_op),
        .m_din       (m_din),
        .m_busy      (m_busy),
        .m_done      (m_done),
        .m_ack_err   (m_ack_err),
        .m_dout      (m_dout)
    );

    // Master model: busy from newd until lat cycles later, then done (or just drop busy when hanging)
    int         mdl_lat  = 10;
    logic       mdl_hang = 1'b0;
    logic [7:0] mdl_dout = 8'h00;
    logic       mdl_err  = 1'b0;
    int         cur_lat;
    logic       cur_hang;
    logic [7:0] cur_dout;
    logic       cur_err;
    int         mcnt;
    logic       mact;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_dout    <= 8'h00;
            m_ack_err <= 1'b0;
            mact      <= 1'b0;
            mcnt      <= 0;
            cur_lat   <= 0;
            cur_hang  <= 1'b0;
            cur_dout  <= 8'h00;
            cur_err   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (mact) begin
                mcnt <= mcnt + 1;
                if (mcnt >= cur_lat) begin
                    mact   <= 1'b0;
                    m_busy <= 1'b0;
                    if (!cur_hang) begin
                        m_done    <= 1'b1;
                        m_dout    <= cur_dout;
                        m_ack_err <= cur_err;
                    end
                end
            end else if (m_newd) begin
                mact     <= 1'b1;
                m_busy   <= 1'b1;
                mcnt     <= 1;
                cur_lat  <= mdl_lat;
                cur_hang <= mdl_hang;
                cur_dout <= mdl_dout;
                cur_err  <= mdl_err;
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [27:0] addr;
        logic [3:0]  op;
        logic [31:0] din;
        int          lat;
        logic [7:0]  dout;
        logic        err;
        logic [3:0]  exp_gnt;
        logic [6:0]  exp_addr;
        logic        exp_op;
        logic [7:0]  exp_din;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One complete transaction with latency, stability and response checks
    task automatic run_vec(input vec_t v, input string nm);
        int   newd_cnt;
        logic unstable;
        logic got;
        mdl_lat  = v.lat;
        mdl_hang = 1'b0;
        mdl_dout = v.dout;
        mdl_err  = v.err;
        req      = v.req;
        req_addr = v.addr;
        req_op   = v.op;
        req_din  = v.din;
        @(negedge clk);
        chk({nm, "_gnt_p1"}, 32'(gnt), 32'(v.exp_gnt));
        chk({nm, "_newd_p1"}, 32'(m_newd), 32'd0);
        @(negedge clk);
        chk({nm, "_newd_p2"}, 32'(m_newd), 32'd1);
        chk({nm, "_m_addr"}, 32'(m_addr), 32'(v.exp_addr));
        chk({nm, "_m_op"}, 32'(m_op), 32'(v.exp_op));
        chk({nm, "_m_din"}, 32'(m_din), 32'(v.exp_din));
        newd_cnt = 1;
        unstable = 1'b0;
        got      = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (m_newd) newd_cnt++;
            if (m_addr !== v.exp_addr || m_op !== v.exp_op || m_din !== v.exp_din) unstable = 1'b1;
            if (rsp_valid != 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "_rsp_seen"}, 32'(got), 32'd1);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(v.exp_gnt));
        chk({nm, "_rsp_data"}, 32'(rsp_data), 32'(v.exp_data));
        chk({nm, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({nm, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        chk({nm, "_newd_count"}, 32'(newd_cnt), 32'd1);
        chk({nm, "_master_if_stable"}, 32'(unstable), 32'd0);
        req = 4'b0;
        @(negedge clk);
        chk({nm, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_gnt_released"}, 32'(gnt), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int         newd_cnt;
        int         cyc;
        logic       got;
        logic       bad;
        logic [3:0] exp_g;
        vec_t       vx;

        vecs[0] = '{4'b0001, {7'h13, 7'h12, 7'h11, 7'h50}, 4'b1110, {8'h33, 8'h22, 8'h11, 8'hA5},
                    500, 8'h00, 1'b0, 4'b0001, 7'h50, 1'b0, 8'hA5, 8'h00, 1'b0};
        vecs[1] = '{4'b0100, {7'h13, 7'h3C, 7'h11, 7'h10}, 4'b0100, {8'h33, 8'h99, 8'h11, 8'h00},
                    40, 8'h7E, 1'b0, 4'b0100, 7'h3C, 1'b1, 8'h99, 8'h7E, 1'b0};
        vecs[2] = '{4'b0010, {7'h13, 7'h12, 7'h22, 7'h10}, 4'b1101, {8'h33, 8'h22, 8'h11, 8'h00},
                    30, 8'hEE, 1'b1, 4'b0010, 7'h22, 1'b0, 8'h11, 8'hEE, 1'b1};
        vecs[3] = '{4'b0011, {7'h13, 7'h12, 7'h22, 7'h2A}, 4'b0000, {8'h33, 8'h22, 8'h11, 8'h5A},
                    25, 8'h01, 1'b0, 4'b0001, 7'h2A, 1'b0, 8'h5A, 8'h01, 1'b0};
        vecs[4] = '{4'b1001, {7'h7F, 7'h12, 7'h22, 7'h2A}, 4'b1000, {8'hFF, 8'h22, 8'h11, 8'h5A},
                    15, 8'hC3, 1'b0, 4'b1000, 7'h7F, 1'b1, 8'hFF, 8'hC3, 1'b0};
        vecs[5] = '{4'b0110, {7'h13, 7'h12, 7'h01, 7'h2A}, 4'b0100, {8'h33, 8'h22, 8'h80, 8'h5A},
                    12, 8'h44, 1'b0, 4'b0010, 7'h01, 1'b0, 8'h80, 8'h44, 1'b0};
        vecs[6] = '{4'b1000, {7'h44, 7'h12, 7'h01, 7'h2A}, 4'b0000, {8'h66, 8'h22, 8'h80, 8'h5A},
                    10, 8'h00, 1'b0, 4'b1000, 7'h44, 1'b0, 8'h66, 8'h00, 1'b0};

        rst      = 1'b1;
        req      = 4'b0;
        req_addr = '0;
        req_op   = '0;
        req_din  = '0;
        repeat (3) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp", 32'({rsp_data, rsp_err, rsp_timeout}), 32'd0);
        chk("reset_master_if", 32'({m_newd, m_addr, m_op, m_din}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_gnt", 32'(gnt), 32'd0);

        // Directed vectors: write, read, NACK, wrap-around and round-robin picks
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Fairness: all requesters held high, pointer currently at 0
        mdl_lat  = 20;
        mdl_hang = 1'b0;
        mdl_dout = 8'h10;
        mdl_err  = 1'b0;
        req_addr = vecs[0].addr;
        req_din  = vecs[0].din;
        req_op   = 4'b0;
        req      = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g    = 4'(1 << (g % 4));
            newd_cnt = 0;
            got      = 1'b0;
            bad      = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (m_newd) newd_cnt++;
                if (gnt != 4'b0) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("fair%0d_gnt_seen", g), 32'(got), 32'd1);
            chk($sformatf("fair%0d_gnt", g), 32'(gnt), 32'(exp_g));
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (m_newd) newd_cnt++;
                if ($countones(gnt) > 1) bad = 1'b1;
                if (gnt == 4'b0) break;
            end
            chk($sformatf("fair%0d_newd_count", g), 32'(newd_cnt), 32'd1);
            chk($sformatf("fair%0d_onehot", g), 32'(bad), 32'd0);
        end
        req = 4'b0;
        repeat (3) @(negedge clk);

        // Timeout: master never completes and holds busy for 3000 cycles
        mdl_lat  = 3000;
        mdl_hang = 1'b1;
        req      = 4'b0100;
        got      = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_newd) begin
                got = 1'b1;
                break;
            end
        end
        chk("tmo_newd_seen", 32'(got), 32'd1);
        cyc = 0;
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        chk("tmo_rsp_seen", 32'(got), 32'd1);
        chk("tmo_latency", 32'(cyc), 32'(TMO));
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'b0100);
        chk("tmo_flags", 32'({rsp_timeout, rsp_err}), 32'b11);
        chk("tmo_data", 32'(rsp_data), 32'd0);
        mdl_lat  = 10;
        mdl_hang = 1'b0;
        mdl_dout = 8'h5C;
        mdl_err  = 1'b0;
        req      = 4'b0010;
        bad      = 1'b0;
        got      = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!m_busy) begin
                got = 1'b1;
                break;
            end
            if (gnt != 4'b0) bad = 1'b1;
            if (!rsp_timeout || !rsp_err || rsp_data != 8'h00) bad = 1'b1;
        end
        chk("tmo_busy_released", 32'(got), 32'd1);
        chk("tmo_no_gnt_hold", 32'(bad), 32'd0);
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        chk("post_tmo_gnt", 32'(gnt), 32'b0010);
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rsp_valid != 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        chk("post_tmo_rsp_seen", 32'(got), 32'd1);
        chk("post_tmo_rsp", 32'({rsp_timeout, rsp_err, rsp_data}), 32'({1'b0, 1'b0, 8'h5C}));
        req = 4'b0;
        repeat (3) @(negedge clk);

        // Move the pointer to 3, then reset mid-transfer on requester 3
        vx = vecs[1];
        vx.dout     = 8'h21;
        vx.exp_data = 8'h21;
        run_vec(vx, "pre_rst");
        mdl_lat  = 2000;
        req      = 4'b1000;
        got      = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_newd) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_newd_seen", 32'(got), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        chk("async_rst_newd", 32'(m_newd), 32'd0);
        chk("async_rst_m_addr", 32'(m_addr), 32'd0);
        req = 4'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vx = '{4'b1010, {7'h5D, 7'h12, 7'h2B, 7'h10}, 4'b0010, {8'h77, 8'h22, 8'h3E, 8'h00},
               10, 8'h9A, 1'b0, 4'b0010, 7'h2B, 1'b1, 8'h3E, 8'h9A, 1'b0};
        run_vec(vx, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
